// File: rtl/instr_queue.sv
// Circular fetch-to-decode instruction FIFO with single-cycle flush.
// Optional same-cycle empty-queue bypass is enabled by defining INSTR_QUEUE_BYPASS_EN.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          flush,
  input  logic          enq,
  input  logic [15:0]   ir_in,
  input  logic [15:0]   pc_in,
  input  logic          hit_in,
  input  logic          predict_in,
  output logic          full,
  output logic [CW-1:0] count,
  input  logic          deq,
  output logic          out_valid,
  output logic [15:0]   ir_out,
  output logic [15:0]   pc_out,
  output logic          hit_out,
  output logic          predict_out
);

  localparam int AW = $clog2(DEPTH);

  logic [33:0]   mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_s, empty_s, wr_s, rd_s;
  logic [33:0]   head_entry_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_s = (count_q == {CW{1'b0}});
  assign rd_s    = deq & ~empty_s;

`ifdef INSTR_QUEUE_BYPASS_EN
  logic bypass_s;
  assign bypass_s = empty_s & enq & ~flush & ~clr;
  // A bypassed instruction that decode takes immediately is never stored.
  assign wr_s     = enq & ~full_s & ~(bypass_s & deq);
`else
  assign wr_s     = enq & ~full_s;
`endif

  // Pointer and occupancy next-state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (wr_s) begin
        tail_d = tail_q + AW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (rd_s) begin
        head_d = head_q + AW'(1);
      end else begin
        head_d = head_q;
      end
      case ({wr_s, rd_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers and entry storage; flush leaves storage untouched.
  always_ff @(posedge clk) begin
    if (clr) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 34'h0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (wr_s && !flush) begin
        mem_q[tail_q] <= {ir_in, pc_in, hit_in, predict_in};
      end
    end
  end

  assign head_entry_s = mem_q[head_q];
  assign full         = full_s;
  assign count        = count_q;

  // Head output selection.
  always_comb begin
    out_valid = ~empty_s;
    {ir_out, pc_out, hit_out, predict_out} = head_entry_s;
`ifdef INSTR_QUEUE_BYPASS_EN
    if (bypass_s) begin
      out_valid = 1'b1;
      {ir_out, pc_out, hit_out, predict_out} = {ir_in, pc_in, hit_in, predict_in};
    end else begin
      out_valid = ~empty_s;
    end
`endif
  end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue against a queue-based reference model.
module tb_instr_queue;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          clr, flush, enq, deq;
  logic [15:0]   ir_in, pc_in;
  logic          hit_in, predict_in;
  logic          full, out_valid, hit_out, predict_out;
  logic [CW-1:0] count;
  logic [15:0]   ir_out, pc_out;

  logic [33:0] mq[$];
  int checks   = 0;
  int failures = 0;

  instr_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clr(clr), .flush(flush), .enq(enq),
    .ir_in(ir_in), .pc_in(pc_in), .hit_in(hit_in), .predict_in(predict_in),
    .full(full), .count(count), .deq(deq), .out_valid(out_valid),
    .ir_out(ir_out), .pc_out(pc_out), .hit_out(hit_out), .predict_out(predict_out)
  );

  always #5 clk = ~clk;

  // Drive one cycle, advance the reference model, then idle the inputs.
  task automatic step(input logic e, input logic d, input logic f, input logic c,
                      input logic [15:0] ir, input logic [15:0] pc,
                      input logic h, input logic p);
    int n;
    logic byp;
    enq = e; deq = d; flush = f; clr = c;
    ir_in = ir; pc_in = pc; hit_in = h; predict_in = p;
    n = mq.size();
    byp = 1'b0;
`ifdef INSTR_QUEUE_BYPASS_EN
    byp = (n == 0) && e && d;
`endif
    if (c || f) begin
      mq.delete();
    end else if (!byp) begin
      if (d && n > 0) void'(mq.pop_front());
      if (e && n < DEPTH) mq.push_back({ir, pc, h, p});
    end
    @(posedge clk);
    #1;
    enq = 1'b0; deq = 1'b0; flush = 1'b0; clr = 1'b0;
    ir_in = 16'h0; pc_in = 16'h0; hit_in = 1'b0; predict_in = 1'b0;
    #1;
  endtask

  task automatic rand_enq(input logic d);
    step(1'b1, d, 1'b0, 1'b0, {1'b0, 15'($urandom)}, 16'($urandom),
         1'($urandom), 1'($urandom));
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom), 1'($urandom), 1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b1, 1'b1);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b1, 1'b1);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (ir_out !== 16'h0) begin failures++; $display("FAIL reset_ir got=%h exp=0000", ir_out); end
    checks++; if (pc_out !== 16'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0000", pc_out); end
    checks++; if ({hit_out, predict_out} !== 2'b00) begin failures++; $display("FAIL reset_bits got=%b%b exp=00", hit_out, predict_out); end
  endtask

  task automatic test_order();
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h5678, 16'h0002, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h9ABC, 16'h0004, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (count !== 4'(3 - i)) begin failures++; $display("FAIL order_count got=%0d exp=%0d", count, 3 - i); end
      checks++; if ({ir_out, pc_out, hit_out, predict_out} !== mq[0]) begin
        failures++; $display("FAIL order_head got=%h exp=%h", {ir_out, pc_out, hit_out, predict_out}, mq[0]); end
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    end
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL order_empty got=%0d/%b exp=0/0", count, out_valid); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) rand_enq(1'b0);
    checks++; if (full !== 1'b1 || count !== 4'd8) begin failures++; $display("FAIL full_flag got=%b/%0d exp=1/8", full, count); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_drop_count got=%0d exp=8", count); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (ir_out === 16'hFFFF || {ir_out, pc_out, hit_out, predict_out} !== mq[0]) begin
        failures++; $display("FAIL full_drain got=%h exp=%h", {ir_out, pc_out, hit_out, predict_out}, mq[0]); end
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL full_drained got=%0d exp=0", count); end
  endtask

  task automatic test_both_same_cycle();
    for (int i = 0; i < DEPTH; i++) rand_enq(1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h7EEE, 16'h1111, 1'b1, 1'b0);
    checks++; if (count !== 4'd7 || full !== 1'b0) begin failures++; $display("FAIL both_full got=%0d/%b exp=7/0", count, full); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    rand_enq(1'b1);
    checks++; if (count !== 4'd4) begin failures++; $display("FAIL both_mid got=%0d exp=4", count); end
    while (mq.size() > 0) begin
      checks++; if ({ir_out, pc_out, hit_out, predict_out} !== mq[0]) begin
        failures++; $display("FAIL both_order got=%h exp=%h", {ir_out, pc_out, hit_out, predict_out}, mq[0]); end
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    end
    rand_enq(1'b0);
    rand_enq(1'b1);
    checks++; if (count !== 4'd1 || {ir_out, pc_out, hit_out, predict_out} !== mq[0]) begin
      failures++; $display("FAIL both_one got=%0d/%h exp=1/%h", count, {ir_out, pc_out, hit_out, predict_out}, mq[0]); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) rand_enq(1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'h3333, 16'h4444, 1'b1, 1'b1);
    checks++; if (count !== 4'd0 || out_valid !== 1'b0 || full !== 1'b0) begin
      failures++; $display("FAIL flush_state got=%0d/%b/%b exp=0/0/0", count, out_valid, full); end
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h2222, 16'h0010, 1'b0, 1'b1);
    checks++; if (ir_out !== 16'h2222 || out_valid !== 1'b1 || count !== 4'd1) begin
      failures++; $display("FAIL flush_after got=%h/%b/%0d exp=2222/1/1", ir_out, out_valid, count); end
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) rand_enq(1'b0);
    for (int i = 0; i < 20; i++) begin
      checks++; if ({ir_out, pc_out, hit_out, predict_out} !== mq[0] || count !== 4'd3) begin
        failures++; $display("FAIL wrap_head got=%h/%0d exp=%h/3", {ir_out, pc_out, hit_out, predict_out}, count, mq[0]); end
      rand_enq(1'b1);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 199) < 1),
           16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      checks++; if (count !== 4'(mq.size()) || full !== (mq.size() == DEPTH) || out_valid !== (mq.size() != 0)) begin
        failures++; $display("FAIL rand_state got=%0d/%b/%b exp=%0d", count, full, out_valid, mq.size()); end
      if (mq.size() != 0) begin
        checks++; if ({ir_out, pc_out, hit_out, predict_out} !== mq[0]) begin
          failures++; $display("FAIL rand_head got=%h exp=%h", {ir_out, pc_out, hit_out, predict_out}, mq[0]); end
      end
    end
  endtask

`ifdef INSTR_QUEUE_BYPASS_EN
  task automatic test_bypass();
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    enq = 1'b1; deq = 1'b1; ir_in = 16'h3333; pc_in = 16'h0040; hit_in = 1'b1; predict_in = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || ir_out !== 16'h3333) begin
      failures++; $display("FAIL bypass_same got=%b/%h exp=1/3333", out_valid, ir_out); end
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h0040, 1'b1, 1'b0);
    checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL bypass_count got=%0d/%b exp=0/0", count, out_valid); end
  endtask
`endif

  initial begin
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
    test_reset();
    test_order();
    test_full();
    test_both_same_cycle();
    test_flush();
    test_wrap();
    test_random();
`ifdef INSTR_QUEUE_BYPASS_EN
    test_bypass();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
